rnd_lfsr_gen: RTL and testbench

//  Parametrised Fibonacci LFSR random-draw engine with a programmable tap mask and OUT_W-bit draws.

---
 rtl/rnd_lfsr_gen_if.sv | 38 +++
 rtl/rnd_lfsr_gen.sv | 107 ++++++++++
 tb/tb_rnd_lfsr_gen.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/rnd_lfsr_gen_if.sv
// Handshake bundle for the LFSR random-draw engine.
// Carries seed load, draw request, result and acceptance signals.
interface rnd_lfsr_gen_if #(
    parameter int WIDTH  = 6,
    parameter int OUT_W  = 2,
    parameter int DCNT_W = 8
);
    logic              seed_ld;
    logic [WIDTH-1:0]  seed;
    logic              start;
    logic              ready;
    logic              busy;
    logic              valid;
    logic [OUT_W-1:0]  rnd_out;
    logic [DCNT_W-1:0] draw_cnt;

    modport master (
        output seed_ld,
        output seed,
        output start,
        output ready,
        input  busy,
        input  valid,
        input  rnd_out,
        input  draw_cnt
    );

    modport slave (
        input  seed_ld,
        input  seed,
        input  start,
        input  ready,
        output busy,
        output valid,
        output rnd_out,
        output draw_cnt
    );
endinterface

// File: rtl/rnd_lfsr_gen.sv
// Fibonacci LFSR random-draw engine: STEPS shifts per draw, result under valid/ready.
// Optional macro RND_ZERO_GUARD_EN replaces any all-zero load with 1 to avoid lockup.
module rnd_lfsr_gen #(
    parameter int               WIDTH      = 6,
    parameter logic [WIDTH-1:0] TAPS       = 6'b101010,
    parameter int               OUT_W      = 2,
    parameter int               STEPS      = 5,
    parameter logic [WIDTH-1:0] RESET_SEED = 1,
    parameter int               DCNT_W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    rnd_lfsr_gen_if.slave bus
);
    localparam int CW = (STEPS < 1) ? 1 : $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  x_q;
    logic [WIDTH-1:0]  x_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [DCNT_W-1:0] dcnt_q;
    logic [DCNT_W-1:0] dcnt_d;
    logic              fb;
    logic [WIDTH-1:0]  x_shift;

    // Any value written into the register passes through here; the zero
    // guard keeps the LFSR out of its all-zero lockup state.
    function automatic logic [WIDTH-1:0] load_val(input logic [WIDTH-1:0] v);
`ifdef RND_ZERO_GUARD_EN
        load_val = (v == '0) ? WIDTH'(1) : v;
`else
        load_val = v;
`endif
    endfunction

    assign fb      = ^(x_q & TAPS);
    assign x_shift = {x_q[WIDTH-2:0], fb};

    // Next-state and datapath update for the draw sequencer.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.seed_ld) begin
                    x_d = load_val(bus.seed);
                end
                if (bus.start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                x_d   = x_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = VALID;
                end
            end
            VALID: begin
                if (bus.ready) begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                    if (bus.start) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any draw in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= load_val(RESET_SEED);
            cnt_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.valid    = (state_q == VALID);
    assign bus.rnd_out  = x_q[WIDTH-1 -: OUT_W];
    assign bus.draw_cnt = dcnt_q;
endmodule

// File: tb/tb_rnd_lfsr_gen.sv
// Directed bench for rnd_lfsr_gen with default parameters.
// Cycle table for a single draw plus hand-written multi-cycle sequences.
module tb_rnd_lfsr_gen;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rnd_lfsr_gen_if #(.WIDTH(6), .OUT_W(2), .DCNT_W(8)) bus ();

    rnd_lfsr_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic       sl;
        logic [5:0] sd;
        logic       st;
        logic       rd;
        logic       ev;
        logic       eb;
        logic [1:0] er;
        logic [7:0] ec;
    } vec_t;

    vec_t tv[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        while (!bus.valid && n < lim) begin
            step();
            n++;
        end
    endtask

    logic [1:0] b2b_exp[3];
    int n;
    int seen;
    logic [1:0] exp_zero;

    initial begin
        // Single draw seeded with 1: x = 000010,000101,001010,010100,101000
        tv[0] = '{1'b1, 6'd1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 8'd0};
        tv[1] = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 8'd0};
        tv[2] = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 8'd0};
        tv[3] = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 8'd0};
        tv[4] = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 8'd0};
        tv[5] = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 8'd0};
        tv[6] = '{1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 8'd1};
        tv[7] = '{1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 8'd1};
        b2b_exp[0] = 2'b00;
        b2b_exp[1] = 2'b10;
        b2b_exp[2] = 2'b01;
`ifdef RND_ZERO_GUARD_EN
        exp_zero = 2'b10;
`else
        exp_zero = 2'b00;
`endif

        rst         = 1'b0;
        bus.seed_ld = 1'b0;
        bus.seed    = '0;
        bus.start   = 1'b0;
        bus.ready   = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_valid", bus.valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rnd", bus.rnd_out, 0);
        chk("rst_cnt", bus.draw_cnt, 0);

        for (int i = 0; i < 8; i++) begin
            bus.seed_ld = tv[i].sl;
            bus.seed    = tv[i].sd;
            bus.start   = tv[i].st;
            bus.ready   = tv[i].rd;
            step();
            chk($sformatf("tv%0d_valid", i), bus.valid, tv[i].ev);
            chk($sformatf("tv%0d_busy", i), bus.busy, tv[i].eb);
            chk($sformatf("tv%0d_rnd", i), bus.rnd_out, tv[i].er);
            chk($sformatf("tv%0d_cnt", i), bus.draw_cnt, tv[i].ec);
        end

        // Back-to-back draws from x=101000 with start held high
        bus.start = 1'b1;
        bus.ready = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            int m;
            wait_valid(12, m);
            n = (k == 0) ? m : m + 1;
            chk($sformatf("b2b%0d_gap", k), n, (k == 0) ? 5 : 6);
            chk($sformatf("b2b%0d_rnd", k), bus.rnd_out, b2b_exp[k]);
            chk($sformatf("b2b%0d_cnt", k), bus.draw_cnt, 1 + k);
            if (k == 2) bus.start = 1'b0;
            step();
        end
        chk("b2b_idle", bus.busy, 0);
        chk("b2b_cnt", bus.draw_cnt, 4);

        // Stall in VALID with start pulses ignored
        bus.seed_ld = 1'b1;
        bus.seed    = 6'd1;
        bus.start   = 1'b1;
        bus.ready   = 1'b0;
        step();
        bus.seed_ld = 1'b0;
        bus.start   = 1'b0;
        wait_valid(8, n);
        chk("stall_lat", n, 5);
        for (int c = 0; c < 10; c++) begin
            bus.start = (c % 3 == 0);
            step();
            chk($sformatf("stall%0d_hold", c),
                {bus.valid, bus.busy, bus.rnd_out}, 4'b1110);
        end
        bus.start = 1'b0;
        bus.ready = 1'b1;
        step();
        chk("stall_acc_valid", bus.valid, 0);
        chk("stall_acc_cnt", bus.draw_cnt, 5);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_valid(8, n);
        chk("stall_next_rnd", bus.rnd_out, 2'b00);
        step();
        chk("stall_next_cnt", bus.draw_cnt, 6);

        // Reset during the third SHIFT cycle
        bus.seed_ld = 1'b1;
        bus.seed    = 6'd9;
        bus.start   = 1'b1;
        step();
        bus.seed_ld = 1'b0;
        bus.start   = 1'b0;
        step();
        step();
        chk("abort_busy_pre", bus.busy, 1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_cnt", bus.draw_cnt, 0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bus.valid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_valid(8, n);
        chk("abort_reseed_rnd", bus.rnd_out, 2'b10);
        step();

        // Zero seed: guarded or locked
        bus.seed_ld = 1'b1;
        bus.seed    = 6'd0;
        step();
        bus.seed_ld = 1'b0;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        wait_valid(8, n);
        chk("zero_lat", n, 5);
        chk("zero_rnd", bus.rnd_out, exp_zero);
        step();
        chk("zero_cnt", bus.draw_cnt, 2);

        // Draw counter wrap
        bus.start = 1'b1;
        n = 0;
        while (!(bus.valid && bus.draw_cnt == 8'd255) && n < 2000) begin
            step();
            n++;
        end
        chk("wrap_reach", {bus.valid, bus.draw_cnt}, 9'h1ff);
        bus.start = 1'b0;
        step();
        chk("wrap_cnt", bus.draw_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
